lsu_mem_arbiter: RTL
====================

Name: lsu_mem_arbiter

Overview:
- Shares one data-memory channel among the NUM_REQ per-thread LSUs of a compute unit.
- Sits between the LSU array and the data-memory controller.
- Round-robin arbitration: one transaction in flight at a time; each requester gets a one-cycle done pulse plus read data.
- Requester-side LSUs stay in REQ/WAIT until their done pulse, so the CU scheduler's WAIT stage waits on this block.

Parameters:
- NUM_REQ, 4, number of requesters (LSUs); must be ≥2.
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 8, memory data width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request; held high until that requester's req_done.
- req_we  input  NUM_REQ  per-requester 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  flattened write data, same slicing.
- req_done  output  NUM_REQ  one-cycle completion pulse, one-hot.
- req_rdata  output  NUM_REQ*DATA_WIDTH  per-requester read-data holding registers.
- mem_valid  output  1  memory request valid.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_ready  input  1  memory accepted/completed request this cycle; read data valid in the same cycle.
- mem_rdata  input  DATA_WIDTH  memory read data.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- All outputs are registered except busy, which is decoded from state.
- Reset values:
  - state IDLE, rr_ptr 0, grant 0.
  - req_done 0, req_rdata all 0.
  - mem_valid 0, mem_we 0, mem_addr 0, mem_wdata 0.
  - busy 0.
- Reset mid-transaction: the transaction is abandoned, no req_done is issued, and the next cycle is IDLE with mem_valid 0.
- State IDLE:
  - If any req_valid is high, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch the selected index into grant, and latch its req_we, addr and wdata into mem_we, mem_addr and mem_wdata.
  - Set mem_valid ← 1 and go to ISSUE.
  - Otherwise stay in IDLE.
- State ISSUE:
  - mem_valid, mem_we, mem_addr and mem_wdata are held stable.
  - On a cycle where mem_ready = 1:
    - clear mem_valid;
    - if the transaction is a read, write mem_rdata into req_rdata[grant];
    - set req_done[grant] ← 1;
    - go to RESPOND.
  - mem_ready = 0: stay in ISSUE, with no timeout.
  - mem_ready while in IDLE or RESPOND is ignored.
- State RESPOND:
  - req_done[grant] is high for exactly this cycle.
  - Set rr_ptr ← (grant+1) mod NUM_REQ, clear req_done, and go to IDLE.
- Latency with a zero-wait memory:
  - req_valid sampled at edge k;
  - mem_valid high in cycle k+1;
  - req_done high in cycle k+2.
  - Back-to-back throughput is one transaction per 3 cycles; each stall cycle of mem_ready adds 1.
- Requester protocol:
  - A requester drops req_valid on the edge ending its done cycle, so the following IDLE cycle does not re-grant it.
  - A requester that keeps req_valid high is treated as a new request. It is re-granted only when no other requester is pending (round-robin).
- req_valid dropped while granted: the in-flight transaction still completes and req_done still pulses.
- Changes to req_* of the granted requester after latching have no effect.
- req_rdata[i] holds its value until the next read completed for requester i; writes leave it unchanged.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,…,NUM_REQ-1,0,…. No requester waits more than NUM_REQ-1 other transactions.
- Round-robin search wrap: with rr_ptr = NUM_REQ-1, the search order is NUM_REQ-1, 0, 1, ….

Test Plan:
- Reset, then req_valid=0001, req_we=0, addr0=0x10, mem_ready tied 1, mem_rdata=0xAB → mem_valid/mem_addr=0x10 one cycle after sampling; req_done=0001 the next cycle; req_rdata[0]=0xAB; busy low afterwards.
- All four requesting reads at addrs 0x00/0x01/0x02/0x03 with mem_ready=1 → grants in order 0,1,2,3; req_done pulses spaced 3 cycles apart; each req_rdata slice gets the matching data.
- After a grant to requester 2 (rr_ptr=3), assert requesters 0 and 3 simultaneously → 3 granted first, then 0.
- Write from requester 1, addr 0x22, wdata 0x5C, with mem_ready low for 5 cycles → mem_valid/mem_we/addr/wdata stable for 6 cycles; req_done[1] one cycle after mem_ready; req_rdata unchanged.
- Assert reset during ISSUE with mem_ready=0 → next cycle mem_valid=0, state IDLE, no req_done pulse, rr_ptr=0.
- Drop req_valid[2] mid-ISSUE → transaction completes and req_done[2] still pulses once.

Source files
------------

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel among the per-thread LSUs.
// One transaction in flight; each requester gets a one-cycle done pulse plus read data.
module lsu_mem_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    req_rdata,
  output logic                             mem_valid,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_ready,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW    = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                grant_q, grant_d;
  logic [NUM_REQ-1:0]              req_done_q, req_done_d;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_rdata_q, req_rdata_d;
  logic                            mem_valid_q, mem_valid_d;
  logic                            mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]           mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]           mem_wdata_q, mem_wdata_d;

  logic                            found_c;
  logic [IDX_W-1:0]                sel_c;
  logic [CW-1:0]                   cand;

  // First pending requester searching upward from rr_ptr, wrapping at NUM_REQ
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = CW'(rr_ptr_q) + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!found_c && req_valid[cand[IDX_W-1:0]]) begin
        found_c = 1'b1;
        sel_c   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found_c)   state_d = ISSUE;
      ISSUE:   if (mem_ready) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration state
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    req_done_d  = '0;
    req_rdata_d = req_rdata_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          grant_d     = sel_c;
          mem_valid_d = 1'b1;
          mem_we_d    = req_we[sel_c];
          mem_addr_d  = req_addr[sel_c*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = req_wdata[sel_c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          mem_valid_d         = 1'b0;
          req_done_d[grant_q] = 1'b1;
          if (!mem_we_q) begin
            req_rdata_d[grant_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
          end
        end
      end
      RESPOND: begin
        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
      end
      default: begin
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      req_done_q  <= '0;
      req_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      req_done_q  <= req_done_d;
      req_rdata_q <= req_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_done  = req_done_q;
  assign req_rdata = req_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule
